sw_debounce_bank: RTL and testbench

//   Per-bit synchroniser and debouncer for a bank of raw switch/key inputs.

---
 rtl/sw_debounce_bank.sv | 126 ++++++++++++
 tb/tb_sw_debounce_bank.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sw_debounce_bank.sv
// ---------------------------------------------------------------------------
// sw_debounce_bank
//   Two-flop synchroniser plus an independent stability filter for each bit
//   of a bank of raw switch/key inputs. The filtered vector drives the
//   priority encoder's request input. The rise/fall strobes mark the single
//   cycle in which a filtered bit changes, so downstream logic can latch a
//   fresh encode result only when a request actually moves.
//
//   Parameters
//     WIDTH            number of input bits
//     CNT_WIDTH        width of each per-bit stability counter
//     DEBOUNCE_CYCLES  consecutive cycles a new level must persist
//                      (1 .. 2**CNT_WIDTH-1)
//
//   Ports
//     clk         in   1      system clock, rising edge
//     rst_n       in   1      synchronous reset, active low
//     raw_in      in   WIDTH  asynchronous, bouncing switch levels
//     stable_out  out  WIDTH  debounced levels
//     rise        out  WIDTH  1-cycle pulse when a stable bit goes 0->1
//     fall        out  WIDTH  1-cycle pulse when a stable bit goes 1->0
//     changed     out  1      OR of all rise/fall strobes, same cycle
// ---------------------------------------------------------------------------
module sw_debounce_bank #(
    parameter int WIDTH           = 8,
    parameter int CNT_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Reject a filter length the counter cannot represent, or a zero length.
    if ((DEBOUNCE_CYCLES < 1) ||
        (longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_WIDTH))) begin : g_param_check
        $error("sw_debounce_bank: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
    end

    // Terminal count: a mismatch seen while the counter holds this value is
    // the DEBOUNCE_CYCLES-th consecutive one, so the new level is accepted.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q,  sync1_d;
    logic [WIDTH-1:0] sync2_q,  sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q,   rise_d;
    logic [WIDTH-1:0] fall_q,   fall_d;
    logic             changed_q, changed_d;

    always_comb begin
        sync1_d   = raw_in;
        sync2_d   = sync1_q;
        changed_d = |(rise_d | fall_d);
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
            logic                 bit_stable_d;
            logic                 bit_rise_d;
            logic                 bit_fall_d;

            // A level matching the stable value (including a glitch back to
            // it) clears the count, so acceptance needs an unbroken run.
            // The counter stops at CNT_LAST because reaching it with a
            // persisting mismatch flips stable, which ends the mismatch.
            always_comb begin
                cnt_d        = '0;
                bit_stable_d = stable_q[gi];
                bit_rise_d   = 1'b0;
                bit_fall_d   = 1'b0;
                if (sync2_q[gi] != stable_q[gi]) begin
                    if (cnt_q == CNT_LAST) begin
                        bit_stable_d = sync2_q[gi];
                        bit_rise_d   = sync2_q[gi];
                        bit_fall_d   = ~sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stable_d[gi] = bit_stable_d;
            assign rise_d[gi]   = bit_rise_d;
            assign fall_d[gi]   = bit_fall_d;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign stable_out = stable_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign changed    = changed_q;

endmodule

// File: tb/tb_sw_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce_bank
//   Directed bench for sw_debounce_bank with WIDTH=8, DEBOUNCE_CYCLES=4.
//   Inputs change just after a rising edge; outputs are sampled 1 time unit
//   after each rising edge. A new raw level set after edge k reaches sync2
//   after edge k+2 and is accepted at edge k+6.
// ---------------------------------------------------------------------------
module tb_sw_debounce_bank;

    localparam int W  = 8;
    localparam int DC = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] raw_in;
    logic [W-1:0] stable_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    int tests_run;
    int tests_failed;

    sw_debounce_bank #(
        .WIDTH           (W),
        .CNT_WIDTH       (16),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .stable_out (stable_out),
        .rise       (rise),
        .fall       (fall),
        .changed    (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] e_stable,
                           input logic [W-1:0] e_rise, input logic [W-1:0] e_fall);
        logic [W-1:0] e_chg;
        e_chg = {{(W-1){1'b0}}, |(e_rise | e_fall)};
        chk({tag, ".stable"},  stable_out, e_stable);
        chk({tag, ".rise"},    rise,       e_rise);
        chk({tag, ".fall"},    fall,       e_fall);
        chk({tag, ".changed"}, {{(W-1){1'b0}}, changed}, e_chg);
    endtask

    // Steps n cycles expecting a constant stable value and no strobes.
    task automatic hold_steady(input string tag, input int n, input logic [W-1:0] e_stable);
        for (int i = 0; i < n; i++) begin
            step();
            chk_all(tag, e_stable, '0, '0);
        end
    endtask

    // raw_in has just been changed: expect the old value for n-1 edges, the
    // new value with the given strobes on edge n, and quiet strobes after.
    task automatic expect_edge(input string tag, input int n,
                               input logic [W-1:0] old_v, input logic [W-1:0] new_v,
                               input logic [W-1:0] e_rise, input logic [W-1:0] e_fall);
        hold_steady({tag, ".wait"}, n - 1, old_v);
        step();
        chk_all({tag, ".edge"}, new_v, e_rise, e_fall);
        step();
        chk_all({tag, ".after"}, new_v, '0, '0);
        $display("[TB] %s: stable %h -> %h after %0d edges", tag, old_v, new_v, n);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // 1: reset held with all inputs high, then release.
        rst_n  = 1'b0;
        raw_in = 8'hFF;
        hold_steady("reset.hold", 3, 8'h00);
        $display("[TB] reset held 3 cycles, outputs quiet");
        rst_n = 1'b1;
        expect_edge("reset.release", 6, 8'h00, 8'hFF, 8'hFF, 8'h00);

        // Return all bits low to set up the press.
        raw_in = 8'h00;
        expect_edge("all_fall", 6, 8'hFF, 8'h00, 8'h00, 8'hFF);

        // 2: clean press of bit 2.
        raw_in = 8'h04;
        expect_edge("press", 6, 8'h00, 8'h04, 8'h04, 8'h00);

        // 3: bit 3 high for 3 cycles only: counter reaches DC-1 and clears.
        raw_in = 8'h0C;
        hold_steady("glitch.high", 3, 8'h04);
        raw_in = 8'h04;
        hold_steady("glitch.low", 10, 8'h04);
        $display("[TB] glitch on bit3 rejected");
        // A full-length press after the glitch must take the full time,
        // which shows the count restarted from 0.
        raw_in = 8'h0C;
        expect_edge("post_glitch_press", 6, 8'h04, 8'h0C, 8'h08, 8'h00);
        raw_in = 8'h04;
        expect_edge("post_glitch_release", 6, 8'h0C, 8'h04, 8'h00, 8'h08);

        // 4: bit 0 bounces 1,0,1,0 then settles at 1.
        raw_in = 8'h05;
        hold_steady("bounce.1", 1, 8'h04);
        raw_in = 8'h04;
        hold_steady("bounce.2", 1, 8'h04);
        raw_in = 8'h05;
        hold_steady("bounce.3", 1, 8'h04);
        raw_in = 8'h04;
        hold_steady("bounce.4", 1, 8'h04);
        raw_in = 8'h05;
        expect_edge("bounce.settle", 6, 8'h04, 8'h05, 8'h01, 8'h00);

        // 5: reach 8'h81, then swap to 8'h18 in one cycle.
        raw_in = 8'h81;
        expect_edge("to_81", 6, 8'h05, 8'h81, 8'h80, 8'h04);
        raw_in = 8'h18;
        expect_edge("simultaneous", 6, 8'h81, 8'h18, 8'h18, 8'h81);

        // 6: bit 5 rises; reset for one cycle once its count is 2.
        raw_in = 8'h38;
        hold_steady("midcount.pre", 4, 8'h18);
        rst_n = 1'b0;
        step();
        chk_all("midcount.reset", 8'h00, '0, '0);
        rst_n = 1'b1;
        expect_edge("midcount.recover", 6, 8'h00, 8'h38, 8'h38, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
